// File: rtl/riscv_pkg.sv
// Shared RISC-V core package.
// Holds the fetch FSM state encoding and the default reset PC used by
// fetch_unit. Import with: import riscv_pkg::*;
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word-aligned read at a time to the
// instruction memory, holds the returned instruction for decode, and follows
// branch/jump/trap redirects.
//
// Ports:
//   clk, resetn          clock (rising edge), async active-low reset
//   imem_req/imem_addr   read request and word-aligned address
//   imem_gnt             request accepted this cycle
//   imem_rvalid/rdata    read response
//   redirect_valid/pc    redirect request and target (bits [1:0] ignored)
//   out_valid/out_ready  handshake towards decode
//   out_instr/out_pc     fetched instruction and its address
//   out_pc_plus4         out_pc + 4 (wraps)
//
// state | meaning
// IDLE  | one cycle after reset release, no request
// REQ   | imem_req asserted at pc, waiting for grant
// WAIT  | request granted, waiting for rvalid
// HOLD  | instruction presented to decode until out_ready
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  fetch_state_t state;
  logic [31:0]  pc;
  // Set when the outstanding response belongs to a path abandoned by a redirect.
  logic         discard;
  logic [31:0]  redir_target;

  assign redir_target = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      discard   <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect_valid) pc <= redir_target;
          state <= ST_REQ;
        end
        ST_REQ: begin
          if (redirect_valid) pc <= redir_target;
          if (imem_gnt) begin
            state <= ST_WAIT;
            // Granted request targets the old pc; its data must be dropped.
            if (redirect_valid) discard <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) pc <= redir_target;
          if (imem_rvalid) begin
            discard <= 1'b0;
            if (discard || redirect_valid) begin
              state <= ST_REQ;
            end else begin
              out_instr <= imem_rdata;
              out_pc    <= pc;
              state     <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            discard <= 1'b1;
          end
        end
        ST_HOLD: begin
          // A redirect wins over sequential advance; a coincident out_ready
          // still completes the transfer towards decode.
          if (redirect_valid) begin
            pc    <= redir_target;
            state <= ST_REQ;
          end else if (out_ready) begin
            pc    <= pc + 32'd4;
            state <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req     = (state == ST_REQ);
  assign imem_addr    = pc;
  assign out_valid    = (state == ST_HOLD);
  assign out_pc_plus4 = out_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table covering the main
// fetch flow, stalls, redirects and PC wrap, followed by a hand-written
// reset-in-WAIT sequence.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit dut (
    .clk           (clk),
    .resetn        (resetn),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc_plus4  (out_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 39;
  vec_t tbl [NV];

  task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_pc);
    cmp("imem_req", idx, {31'd0, imem_req}, {31'd0, e_req});
    cmp("imem_addr", idx, imem_addr, e_addr);
    cmp("out_valid", idx, {31'd0, out_valid}, {31'd0, e_valid});
    cmp("out_instr", idx, out_instr, e_instr);
    cmp("out_pc", idx, out_pc, e_pc);
    cmp("out_pc_plus4", idx, out_pc_plus4, e_pc + 32'd4);
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic gnt,
                       input logic rvalid, input logic [31:0] rdata, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_gnt       = gnt;
    imem_rvalid    = rvalid;
    imem_rdata     = rdata;
    out_ready      = rdy;
  endtask

  initial begin
    //          rv  rpc           gnt rvl rdata         rdy  req addr          vld instr         pc
    tbl[0]  = '{0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0};
    tbl[1]  = '{0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0,        32'h0};
    tbl[2]  = '{0, 32'h0,        0, 1, 32'h00500093, 0,   0, 32'h0,        0, 32'h0,        32'h0};
    tbl[3]  = '{0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h0,        1, 32'h00500093, 32'h0};
    tbl[4]  = '{0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h4,        0, 32'h00500093, 32'h0};
    tbl[5]  = '{0, 32'h0,        0, 1, 32'hAAAA0001, 1,   0, 32'h4,        0, 32'h00500093, 32'h0};
    tbl[6]  = '{0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h4,        1, 32'hAAAA0001, 32'h4};
    tbl[7]  = '{0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h8,        0, 32'hAAAA0001, 32'h4};
    tbl[8]  = '{0, 32'h0,        0, 1, 32'hBBBB0002, 0,   0, 32'h8,        0, 32'hAAAA0001, 32'h4};
    tbl[9]  = '{0, 32'h0,        0, 1, 32'hFFFFFFFF, 0,   0, 32'h8,        1, 32'hBBBB0002, 32'h8};
    tbl[10] = '{0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h8,        1, 32'hBBBB0002, 32'h8};
    tbl[11] = '{0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h8,        1, 32'hBBBB0002, 32'h8};
    tbl[12] = '{0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h8,        1, 32'hBBBB0002, 32'h8};
    tbl[13] = '{0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h8,        1, 32'hBBBB0002, 32'h8};
    tbl[14] = '{0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h8,        1, 32'hBBBB0002, 32'h8};
    tbl[15] = '{0, 32'h0,        0, 0, 32'h0,        0,   1, 32'hC,        0, 32'hBBBB0002, 32'h8};
    tbl[16] = '{0, 32'h0,        0, 0, 32'h0,        0,   1, 32'hC,        0, 32'hBBBB0002, 32'h8};
    tbl[17] = '{0, 32'h0,        1, 0, 32'h0,        0,   1, 32'hC,        0, 32'hBBBB0002, 32'h8};
    tbl[18] = '{1, 32'h102,      0, 0, 32'h0,        0,   0, 32'hC,        0, 32'hBBBB0002, 32'h8};
    tbl[19] = '{0, 32'h0,        0, 1, 32'hDEAD0000, 0,   0, 32'h100,      0, 32'hBBBB0002, 32'h8};
    tbl[20] = '{0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h100,      0, 32'hBBBB0002, 32'h8};
    tbl[21] = '{0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h100,      0, 32'hBBBB0002, 32'h8};
    tbl[22] = '{0, 32'h0,        0, 1, 32'h11110000, 0,   0, 32'h100,      0, 32'hBBBB0002, 32'h8};
    tbl[23] = '{0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h100,      1, 32'h11110000, 32'h100};
    tbl[24] = '{1, 32'hFFFFFFFC, 0, 0, 32'h0,        0,   1, 32'h104,      0, 32'h11110000, 32'h100};
    tbl[25] = '{0, 32'h0,        1, 0, 32'h0,        0,   1, 32'hFFFFFFFC, 0, 32'h11110000, 32'h100};
    tbl[26] = '{0, 32'h0,        0, 1, 32'h22220000, 0,   0, 32'hFFFFFFFC, 0, 32'h11110000, 32'h100};
    tbl[27] = '{0, 32'h0,        0, 0, 32'h0,        1,   0, 32'hFFFFFFFC, 1, 32'h22220000, 32'hFFFFFFFC};
    tbl[28] = '{1, 32'h200,      1, 0, 32'h0,        0,   1, 32'h0,        0, 32'h22220000, 32'hFFFFFFFC};
    tbl[29] = '{0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h200,      0, 32'h22220000, 32'hFFFFFFFC};
    tbl[30] = '{0, 32'h0,        0, 1, 32'h33330000, 0,   0, 32'h200,      0, 32'h22220000, 32'hFFFFFFFC};
    tbl[31] = '{0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h200,      0, 32'h22220000, 32'hFFFFFFFC};
    tbl[32] = '{1, 32'h300,      0, 1, 32'h44440000, 0,   0, 32'h200,      0, 32'h22220000, 32'hFFFFFFFC};
    tbl[33] = '{0, 32'h0,        1, 1, 32'h55550000, 0,   1, 32'h300,      0, 32'h22220000, 32'hFFFFFFFC};
    tbl[34] = '{0, 32'h0,        0, 1, 32'h66660000, 0,   0, 32'h300,      0, 32'h22220000, 32'hFFFFFFFC};
    tbl[35] = '{1, 32'h400,      0, 0, 32'h0,        1,   0, 32'h300,      1, 32'h66660000, 32'h300};
    tbl[36] = '{0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h400,      0, 32'h66660000, 32'h300};
    tbl[37] = '{0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h400,      0, 32'h66660000, 32'h300};
    tbl[38] = '{0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h400,      0, 32'h66660000, 32'h300};

    resetn = 1'b0;
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    @(negedge clk);
    check_all(100, 0, 32'h0, 0, 32'h0, 32'h0);

    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (i > 0) @(negedge clk);
      drive(tbl[i].rv, tbl[i].rpc, tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].rdy);
      check_all(i, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_instr, tbl[i].e_pc);
    end

    // Reset pulse while a request is outstanding (state is WAIT here).
    #2 resetn = 1'b0;
    #1 check_all(200, 0, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    // IDLE with the abandoned response arriving late.
    drive(0, 32'h0, 0, 1, 32'h77770000, 1);
    check_all(201, 0, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk);
    drive(0, 32'h0, 0, 1, 32'h88880000, 1);
    check_all(202, 1, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk);
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    check_all(203, 1, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk);
    drive(0, 32'h0, 0, 1, 32'h12345678, 1);
    check_all(204, 0, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 32'h0, 1);
    check_all(205, 0, 32'h0, 1, 32'h12345678, 32'h0);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    check_all(206, 1, 32'h4, 0, 32'h12345678, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: bench still running at %0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
